// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    // Sequencer states (2-bit encoding).
    typedef enum logic [1:0] {
        StBoot = 2'd0,
        StRun  = 2'd1,
        StHalt = 2'd2,
        StErr  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned DEFAULT_PC_STEP  = 4;
    localparam logic [31:0] WORD_ALIGN_MASK  = 32'h0000_0003;

    // True when an address is not on a 32-bit word boundary.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return |(addr & WORD_ALIGN_MASK);
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// Decode-facing output register backed by a single skid entry.
// Entries leave in program order: the skid always refills the output before a new push does.
module fetch_skid (
    input  logic        i_clk,
    input  logic        i_reset,      // asynchronous, active low
    input  logic        i_flush,
    input  logic        i_push,
    input  logic [31:0] i_push_pc,
    input  logic [31:0] i_push_inst,
    input  logic        i_pop,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_inst,
    output logic [1:0]  o_occupancy
);

    logic        r_out_valid;
    logic [31:0] r_out_pc;
    logic [31:0] r_out_inst;
    logic        r_skid_valid;
    logic [31:0] r_skid_pc;
    logic [31:0] r_skid_inst;

    logic        w_out_free;

    // Output register can take new data when empty or being consumed this cycle.
    always_comb begin
        w_out_free  = !r_out_valid || i_pop;
        o_valid     = r_out_valid;
        o_pc        = r_out_pc;
        o_inst      = r_out_inst;
        o_occupancy = {1'b0, r_out_valid} + {1'b0, r_skid_valid};
    end

    // Output/skid update: flush drops both entries, otherwise shift skid forward and accept pushes.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_out_valid  <= 1'b0;
            r_out_pc     <= '0;
            r_out_inst   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_pc    <= '0;
            r_skid_inst  <= '0;
        end else if (i_flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_out_pc     <= r_skid_pc;
                r_out_inst   <= r_skid_inst;
                r_skid_valid <= i_push;
                if (i_push) begin
                    r_skid_pc   <= i_push_pc;
                    r_skid_inst <= i_push_inst;
                end
            end else begin
                r_out_valid <= i_push;
                if (i_push) begin
                    r_out_pc   <= i_push_pc;
                    r_out_inst <= i_push_inst;
                end
            end
        end else if (i_push) begin
            // Output is stalled; the issue gate guarantees the skid is empty here.
            r_skid_valid <= 1'b1;
            r_skid_pc    <= i_push_pc;
            r_skid_inst  <= i_push_inst;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the synchronous ROM, follows redirects,
// honours halt, and buffers responses so decode back-pressure never drops an instruction.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic        i_clk,
    input  logic        i_reset,          // asynchronous, active low
    input  logic        i_halt_req,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_rom_en,
    output logic [31:0] o_rom_addr,
    input  logic [31:0] i_rom_inst,
    input  logic        i_id_ready,
    output logic        o_if_valid,
    output logic [31:0] o_if_pc,
    output logic [31:0] o_if_inst,
    output logic        o_fetch_err
);

    localparam logic [31:0] PcStep = 32'(PC_STEP);

    fetch_state_e r_state;
    fetch_state_e w_state_next;
    logic [31:0]  r_fetch_pc;
    logic [31:0]  r_req_pc;
    logic         r_inflight;
    logic         r_fetch_err;

    logic         w_issue;
    logic         w_pop;
    logic         w_misaligned;
    logic [1:0]   w_buf_occ;
    logic [1:0]   w_occ_total;
    logic [1:0]   w_occ_after_pop;

    // Output register + skid entry; a redirect flushes both.
    fetch_skid u_skid (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_flush     (i_redirect_valid),
        .i_push      (r_inflight),
        .i_push_pc   (r_req_pc),
        .i_push_inst (i_rom_inst),
        .i_pop       (w_pop),
        .o_valid     (o_if_valid),
        .o_pc        (o_if_pc),
        .o_inst      (o_if_inst),
        .o_occupancy (w_buf_occ)
    );

    // Only issue when the result is guaranteed a slot (output or skid) after this cycle's pop.
    always_comb begin
        w_pop           = o_if_valid && i_id_ready;
        w_misaligned    = is_misaligned(i_redirect_pc);
        w_occ_total     = w_buf_occ + {1'b0, r_inflight};
        w_occ_after_pop = w_occ_total - {1'b0, w_pop};
        w_issue         = (r_state == StRun) && !i_halt_req && !i_redirect_valid &&
                          (w_occ_after_pop < 2'd2);
        o_rom_en        = w_issue;
        o_rom_addr      = r_fetch_pc;
        o_fetch_err     = r_fetch_err;
    end

    // Next-state: misaligned redirect traps, aligned redirect releases ERR, else halt handling.
    always_comb begin
        w_state_next = r_state;
        if (i_redirect_valid && w_misaligned) begin
            w_state_next = StErr;
        end else if (i_redirect_valid && (r_state == StErr)) begin
            w_state_next = StRun;
        end else begin
            unique case (r_state)
                StBoot:  w_state_next = StRun;
                StRun:   w_state_next = i_halt_req ? StHalt : StRun;
                StHalt:  w_state_next = i_halt_req ? StHalt : StRun;
                StErr:   w_state_next = StErr;
                default: w_state_next = StBoot;
            endcase
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= StBoot;
        end else begin
            r_state <= w_state_next;
        end
    end

    // PC, in-flight tag and sticky error; redirect discards the outstanding ROM response.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_fetch_pc  <= RESET_PC;
            r_req_pc    <= '0;
            r_inflight  <= 1'b0;
            r_fetch_err <= 1'b0;
        end else if (i_redirect_valid) begin
            r_fetch_pc  <= i_redirect_pc;
            r_inflight  <= 1'b0;
            r_fetch_err <= w_misaligned;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_req_pc   <= r_fetch_pc;
                r_fetch_pc <= r_fetch_pc + PcStep;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: hand-derived accepted-instruction stream checked by a
// scoreboard monitor, plus cycle-accurate checks of ROM strobes, halt, redirect and reset.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        halt_req;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic [31:0] rom_inst;
    logic [31:0] rom_inst_w;

    logic        rom_en,   w_rom_en;
    logic [31:0] rom_addr, w_rom_addr;
    logic        if_valid, w_if_valid;
    logic [31:0] if_pc,    w_if_pc;
    logic [31:0] if_inst,  w_if_inst;
    logic        fetch_err, w_fetch_err;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] sb_exp;

    always #5 clk = ~clk;

    fetch_ctrl u_dut (
        .i_clk            (clk),
        .i_reset          (rst_n),
        .i_halt_req       (halt_req),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .o_rom_en         (rom_en),
        .o_rom_addr       (rom_addr),
        .i_rom_inst       (rom_inst),
        .i_id_ready       (id_ready),
        .o_if_valid       (if_valid),
        .o_if_pc          (if_pc),
        .o_if_inst        (if_inst),
        .o_fetch_err      (fetch_err)
    );

    // Second instance only exercises the PC wrap from a high reset address.
    fetch_ctrl #(
        .RESET_PC (32'hFFFF_FFF8)
    ) u_wrap (
        .i_clk            (clk),
        .i_reset          (rst_n),
        .i_halt_req       (halt_req),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .o_rom_en         (w_rom_en),
        .o_rom_addr       (w_rom_addr),
        .i_rom_inst       (rom_inst_w),
        .i_id_ready       (id_ready),
        .o_if_valid       (w_if_valid),
        .o_if_pc          (w_if_pc),
        .o_if_inst        (w_if_inst),
        .o_fetch_err      (w_fetch_err)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return ~a ^ 32'h5A5A_1234;
    endfunction

    // Synchronous ROM models: data valid the cycle after the strobe.
    always @(posedge clk) if (rom_en) rom_inst <= inst_of(rom_addr);
    always @(posedge clk) if (w_rom_en) rom_inst_w <= inst_of(w_rom_addr);

    // Scoreboard monitor: every accepted instruction must be the next expected one.
    always @(negedge clk) begin
        if (rst_n && if_valid && id_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_extra: got pc 0x%08h, expected no instruction", if_pc);
            end else begin
                sb_exp = exp_q.pop_front();
                if (if_pc !== sb_exp || if_inst !== inst_of(sb_exp)) begin
                    n_fail++;
                    $display("FAIL sb_order: got pc 0x%08h inst 0x%08h, expected pc 0x%08h inst 0x%08h",
                             if_pc, if_inst, sb_exp, inst_of(sb_exp));
                end
            end
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected bench to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_list[$];
        exp_list = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20,
                     32'h100, 32'h104, 32'h180, 32'h184, 32'h200, 32'h204,
                     32'h38, 32'h3C, 32'h40,
                     32'h00, 32'h04, 32'h08, 32'h0C};
        foreach (exp_list[i]) exp_q.push_back(exp_list[i]);

        rst_n = 1'b1; halt_req = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check32("rst_rom_en",    {31'd0, rom_en},    32'd0);
        check32("rst_rom_addr",  rom_addr,           32'h0);
        check32("rst_if_valid",  {31'd0, if_valid},  32'd0);
        check32("rst_if_pc",     if_pc,              32'h0);
        check32("rst_if_inst",   if_inst,            32'h0);
        check32("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
        check32("wrap_rst_addr", w_rom_addr,         32'hFFFF_FFF8);
        check32("wrap_rst_en",   {31'd0, w_rom_en},  32'd0);
        check32("wrap_rst_out",  {w_if_valid, w_fetch_err, 30'd0} | w_if_pc | w_if_inst, 32'd0);

        cyc(); cyc();
        rst_n = 1'b1;                                           // BOOT cycle
        #2 check32("boot_no_fetch", {31'd0, rom_en}, 32'd0);
        cyc(); #2;                                              // +1
        check32("f0_en",   {31'd0, rom_en}, 32'd1);
        check32("f0_addr", rom_addr, 32'h0);
        check32("wrap0",   w_rom_addr, 32'hFFFF_FFF8);
        cyc(); #2;                                              // +2
        check32("f1_addr",    rom_addr, 32'h4);
        check32("f1_nvalid",  {31'd0, if_valid}, 32'd0);
        check32("wrap1",      w_rom_addr, 32'hFFFF_FFFC);
        cyc(); #2;                                              // +3
        check32("f2_addr",   rom_addr, 32'h8);
        check32("lat_valid", {31'd0, if_valid}, 32'd1);
        check32("lat_pc",    if_pc, 32'h0);
        check32("lat_inst",  if_inst, inst_of(32'h0));
        check32("wrap2",     w_rom_addr, 32'h0);
        repeat (4) cyc();                                       // +4..+7

        // Five-cycle decode stall: two entries buffered, no new fetch.
        cyc(); id_ready = 1'b0;                                 // +8
        #2 check32("stall_en0", {31'd0, rom_en}, 32'd0);
        for (int i = 0; i < 4; i++) begin                       // +9..+12
            cyc(); #2;
            check32("stall_en", {31'd0, rom_en}, 32'd0);
            check32("stall_hold_pc", if_pc, 32'h14);
        end
        cyc(); id_ready = 1'b1;                                 // +13
        #2;
        check32("resume_en",   {31'd0, rom_en}, 32'd1);
        check32("resume_addr", rom_addr, 32'h1C);
        repeat (3) cyc();                                       // +14..+16

        // Fill the skid, then redirect to 0x100.
        cyc(); id_ready = 1'b0;                                 // +17
        #2 check32("fill_en", {31'd0, rom_en}, 32'd0);
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h100;    // +18
        #2;
        check32("redir_en",  {31'd0, rom_en}, 32'd0);
        check32("redir_pc0", if_pc, 32'h24);
        cyc(); redirect_valid = 1'b0; id_ready = 1'b1;          // +19
        #2;
        check32("redir_flush", {31'd0, if_valid}, 32'd0);
        check32("redir_en1",   {31'd0, rom_en}, 32'd1);
        check32("redir_addr",  rom_addr, 32'h100);
        repeat (2) cyc();                                       // +20,+21

        // Redirect with a request in flight and a consumed output.
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h180;    // +22
        #2;
        check32("redir2_pc", if_pc, 32'h104);
        check32("redir2_en", {31'd0, rom_en}, 32'd0);
        cyc(); redirect_valid = 1'b0;                           // +23
        #2 check32("redir2_addr", rom_addr, 32'h180);
        repeat (2) cyc();                                       // +24,+25

        // Misaligned redirect traps; aligned redirect recovers.
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h102;    // +26
        cyc(); redirect_valid = 1'b0;                           // +27
        #2;
        check32("err_flag",  {31'd0, fetch_err}, 32'd1);
        check32("err_en",    {31'd0, rom_en}, 32'd0);
        check32("err_addr",  rom_addr, 32'h102);
        check32("err_flush", {31'd0, if_valid}, 32'd0);
        cyc(); #2 check32("err_en2", {31'd0, rom_en}, 32'd0);  // +28
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h200;    // +29
        #2 check32("err_hold", {31'd0, fetch_err}, 32'd1);
        cyc(); redirect_valid = 1'b0;                           // +30
        #2;
        check32("err_clr",  {31'd0, fetch_err}, 32'd0);
        check32("err_en3",  {31'd0, rom_en}, 32'd1);
        check32("err_addr3", rom_addr, 32'h200);
        repeat (2) cyc();                                       // +31,+32

        // Halt for three cycles with fetch_pc at 0x40.
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h38;     // +33
        cyc(); redirect_valid = 1'b0;                           // +34
        #2 check32("pre_halt_addr", rom_addr, 32'h38);
        cyc();                                                  // +35
        cyc(); halt_req = 1'b1;                                 // +36
        #2;
        check32("halt_en_same", {31'd0, rom_en}, 32'd0);
        check32("halt_addr",    rom_addr, 32'h40);
        cyc(); #2;                                              // +37
        check32("halt_en1",    {31'd0, rom_en}, 32'd0);
        check32("halt_drain",  if_pc, 32'h3C);
        cyc(); #2 check32("halt_en2", {31'd0, rom_en}, 32'd0);  // +38
        cyc(); halt_req = 1'b0;                                 // +39
        #2 check32("halt_exit_en", {31'd0, rom_en}, 32'd0);
        cyc(); #2;                                              // +40
        check32("halt_resume_en",   {31'd0, rom_en}, 32'd1);
        check32("halt_resume_addr", rom_addr, 32'h40);
        cyc(); cyc();                                           // +41,+42

        // Asynchronous reset mid-burst.
        cyc(); #2 rst_n = 1'b0;                                 // +43
        #1;
        check32("arst_if_valid",  {31'd0, if_valid},  32'd0);
        check32("arst_if_pc",     if_pc,              32'h0);
        check32("arst_if_inst",   if_inst,            32'h0);
        check32("arst_rom_en",    {31'd0, rom_en},    32'd0);
        check32("arst_rom_addr",  rom_addr,           32'h0);
        check32("arst_fetch_err", {31'd0, fetch_err}, 32'd0);
        cyc(); cyc();
        rst_n = 1'b1;                                           // BOOT again
        repeat (6) cyc();
        cyc(); id_ready = 1'b0;
        repeat (3) cyc();

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d unconsumed entries, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
